sfx_strobe_gen: RTL and testbench
=================================

Name: sfx_strobe_gen

Overview:
Sound-effect sequencer that sits directly upstream of the DAC counter. It generates the `at_max` strobe that advances `dacCount`. On a game event (good or bad collision) it plays a fixed 4-note sequence. Each note is a strobe train at a note-specific period, so the pitch of the DAC waveform is set here. Between effects it holds `at_max` low, so the DAC counter idles.

Parameters:
- DIV_W, 16, width of the tone-period and note-length counters.
- BASE_DIV, 8, strobe period in clk cycles for note 0 of either sequence.
- STEP_DIV, 2, period change per note index k.
  - Good sequence period = BASE_DIV - k*STEP_DIV (pitch rises).
  - Bad sequence period = BASE_DIV + k*STEP_DIV (pitch falls).
  - Legal only if BASE_DIV > 3*STEP_DIV, BASE_DIV + 3*STEP_DIV < 2^DIV_W, and STEP_DIV ≥ 1.
- NOTE_LEN, 40, length of each note in clk cycles (≥ 1).
- REST_LEN, 10, silent cycles after note 3 before returning to IDLE (≥ 1).

Ports:
- clk, input, 1, system clock.
- nRst, input, 1, reset; asynchronous, active-low.
- good_coll, input, 1, one-cycle pulse: snake ate food.
- bad_coll, input, 1, one-cycle pulse: snake hit wall or itself.
- at_max, output, 1, registered one-cycle strobe to the DAC counter.
- playing, output, 1, high while in PLAY.
- note_idx, output, 2, index of the current note (0–3).
- seq_bad, output, 1, 1 when the current or last sequence is the bad sequence.

Behaviour:
- **Reset:** nRst low asynchronously forces state=IDLE. All outputs and internal counters go to 0. This applies at any point, including mid-note.
- **States:** IDLE, PLAY, REST.
- **Event priority:** bad_coll beats good_coll. When both are sampled high in the same cycle, the bad sequence starts.
- **IDLE:**
  - at_max=0, playing=0.
  - An event at posedge moves to PLAY on that edge, with note_idx=0 and seq_bad set from the event.
  - tone_cnt and note_cnt are cleared on that edge.
- **PLAY:**
  - tone_cnt and note_cnt both increment every cycle.
  - When tone_cnt reaches period(k)-1, at_max is registered high for the next cycle and tone_cnt wraps to 0.
  - First strobe appears period(k) cycles after note start. Each note yields exactly floor(NOTE_LEN/period(k)) strobes.
  - When note_cnt reaches NOTE_LEN-1, both counters clear and note_idx increments.
  - After note 3 the block goes to REST.
- **Period calculation:** computed combinationally at DIV_W bits from seq_bad and note_idx. No wrap is possible under the legal parameter range.
- **Events during PLAY:**
  - bad_coll restarts the bad sequence at note 0 with counters cleared, whether the current sequence is good or bad.
  - good_coll during PLAY is ignored.
- **REST:**
  - at_max=0, playing=0; note_idx holds 3.
  - Counts REST_LEN cycles, then goes to IDLE with note_idx=0.
  - Any event during REST starts a new sequence immediately, with the same priority rules as IDLE.
- **Strobe pipelining:** at_max pending at the final PLAY cycle is still emitted once. A strobe is never emitted in IDLE except as the last pipelined strobe of a note.
- **seq_bad:** holds its value through REST and IDLE until the next sequence starts.

Optional Feature:
- **Macro:** SFX_MUTE_EN.
- **When defined:**
  - Adds input port `mute` (1 bit).
  - While mute=1, at_max is forced to 0.
  - State, counters, playing and note_idx advance exactly as unmuted, so unmuting mid-note resumes the strobe on the correct phase.
- **When undefined:** no mute port; behaviour as above.

Test Plan:
1. **Reset:** nRst=0 mid-PLAY, checked 2 ns later off-edge → at_max=0, playing=0, note_idx=0, seq_bad=0 before any clock edge. After release, with no events, outputs stay 0 for 20 cycles.
2. **Good sequence** (defaults): one good_coll pulse from IDLE.
   - Per-note strobe counts 5/6/10/20, 41 total.
   - Strobe spacing 8/6/4/2.
   - playing high for exactly 160 cycles, then 10 REST cycles, then IDLE.
3. **Bad sequence:** one bad_coll pulse.
   - Periods 8/10/12/14; counts 5/4/3/2, 14 total.
   - seq_bad=1 throughout and held afterwards.
4. **Preemption and ignore:**
   - good_coll, then bad_coll at cycle 90 (in note 2) → note_idx=0, seq_bad=1, next strobe 8 cycles later, full 160-cycle bad sequence.
   - good_coll during bad PLAY → no change.
5. **Simultaneous and REST:**
   - good_coll and bad_coll in the same cycle → bad sequence starts.
   - good_coll in the 5th REST cycle → good sequence starts on the next edge, first strobe 8 cycles later.
6. **(SFX_MUTE_EN)** Good sequence with mute=1 over cycles 0–79 → zero strobes in notes 0–1. Note 2 produces 10 strobes and note 3 produces 20. playing timing is unchanged.

Source files
------------

// File: rtl/sfx_strobe_gen.sv
// Sound-effect sequencer: plays a 4-note strobe train on at_max for the DAC counter.
// Optional build macro SFX_MUTE_EN adds a mute input that masks at_max only.
module sfx_strobe_gen #(
    parameter int DIV_W    = 16,
    parameter int BASE_DIV = 8,
    parameter int STEP_DIV = 2,
    parameter int NOTE_LEN = 40,
    parameter int REST_LEN = 10
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       good_coll,
    input  logic       bad_coll,
`ifdef SFX_MUTE_EN
    input  logic       mute,
`endif
    output logic       at_max,
    output logic       playing,
    output logic [1:0] note_idx,
    output logic       seq_bad
);

    typedef enum logic [1:0] {IDLE, PLAY, REST} state_t;

    localparam logic [DIV_W-1:0] BASE_W    = DIV_W'(BASE_DIV);
    localparam logic [DIV_W-1:0] STEP_W    = DIV_W'(STEP_DIV);
    localparam logic [DIV_W-1:0] NOTE_LAST = DIV_W'(NOTE_LEN - 1);
    localparam logic [DIV_W-1:0] REST_LAST = DIV_W'(REST_LEN - 1);
    localparam logic [DIV_W-1:0] ONE_W     = DIV_W'(1);

    state_t           state, state_next;
    logic [DIV_W-1:0] tone_cnt, tone_next;
    logic [DIV_W-1:0] note_cnt, note_next;
    logic [1:0]       idx_next;
    logic             bad_next;
    logic             strobe_next;
    logic             strobe_gated;
    logic [DIV_W-1:0] step_off;
    logic [DIV_W-1:0] period;
    logic             tone_hit;

    // Good sequence rises in pitch (shorter period), bad sequence falls.
    assign step_off = STEP_W * DIV_W'(note_idx);
    assign period   = seq_bad ? (BASE_W + step_off) : (BASE_W - step_off);
    assign tone_hit = (tone_cnt == (period - ONE_W));
    assign playing  = (state == PLAY);

`ifdef SFX_MUTE_EN
    assign strobe_gated = strobe_next & ~mute;
`else
    assign strobe_gated = strobe_next;
`endif

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state    <= IDLE;
            tone_cnt <= '0;
            note_cnt <= '0;
            note_idx <= 2'd0;
            seq_bad  <= 1'b0;
            at_max   <= 1'b0;
        end else begin
            state    <= state_next;
            tone_cnt <= tone_next;
            note_cnt <= note_next;
            note_idx <= idx_next;
            seq_bad  <= bad_next;
            at_max   <= strobe_gated;
        end
    end

    // note_cnt doubles as the rest-length counter while in REST.
    always_comb begin
        state_next  = state;
        tone_next   = tone_cnt;
        note_next   = note_cnt;
        idx_next    = note_idx;
        bad_next    = seq_bad;
        strobe_next = 1'b0;

        case (state)
            IDLE, REST: begin
                if (good_coll || bad_coll) begin
                    state_next = PLAY;
                    tone_next  = '0;
                    note_next  = '0;
                    idx_next   = 2'd0;
                    bad_next   = bad_coll;
                end else if (state == REST) begin
                    if (note_cnt == REST_LAST) begin
                        state_next = IDLE;
                        note_next  = '0;
                        idx_next   = 2'd0;
                    end else begin
                        note_next = note_cnt + ONE_W;
                    end
                end
            end
            PLAY: begin
                if (bad_coll) begin
                    tone_next = '0;
                    note_next = '0;
                    idx_next  = 2'd0;
                    bad_next  = 1'b1;
                end else begin
                    strobe_next = tone_hit;
                    tone_next   = tone_hit ? '0 : (tone_cnt + ONE_W);
                    if (note_cnt == NOTE_LAST) begin
                        tone_next = '0;
                        note_next = '0;
                        if (note_idx == 2'd3) begin
                            state_next = REST;
                        end else begin
                            idx_next = note_idx + 2'd1;
                        end
                    end else begin
                        note_next = note_cnt + ONE_W;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sfx_strobe_gen.sv
// Directed bench for sfx_strobe_gen: per-note strobe counts, spacing, timing and event priority.
// Sample n of a sequence is taken on the negedge after the n-th posedge following the event edge.
module tb_sfx_strobe_gen;

    logic       tb_clk = 1'b0;
    logic       nRst;
    logic       good_coll;
    logic       bad_coll;
`ifdef SFX_MUTE_EN
    logic       mute;
`endif
    logic       at_max;
    logic       playing;
    logic [1:0] note_idx;
    logic       seq_bad;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    logic       strobe_hist [0:399];
    logic       play_hist   [0:399];
    logic [1:0] idx_hist    [0:399];
    logic       bad_hist    [0:399];

    sfx_strobe_gen dut (
        .clk      (tb_clk),
        .nRst     (nRst),
        .good_coll(good_coll),
        .bad_coll (bad_coll),
`ifdef SFX_MUTE_EN
        .mute     (mute),
`endif
        .at_max   (at_max),
        .playing  (playing),
        .note_idx (note_idx),
        .seq_bad  (seq_bad)
    );

    initial forever #5 tb_clk = ~tb_clk;

    // Drive one event cycle; returns at sample 0 of the started sequence.
    task automatic pulse(input logic g, input logic b);
        @(negedge tb_clk);
        good_coll = g;
        bad_coll  = b;
        @(negedge tb_clk);
        good_coll = 1'b0;
        bad_coll  = 1'b0;
    endtask

    // Record outputs for samples 0..cycles-1; optionally pulse good_coll at sample inj_n.
    task automatic observe(input int cycles, input int inj_n);
        for (int n = 0; n < cycles; n++) begin
            if (n > 0) @(negedge tb_clk);
            good_coll      = 1'b0;
            strobe_hist[n] = at_max;
            play_hist[n]   = playing;
            idx_hist[n]    = note_idx;
            bad_hist[n]    = seq_bad;
            if (n == inj_n) good_coll = 1'b1;
        end
        good_coll = 1'b0;
    endtask

    function automatic int count_strobes(input int lo, input int hi);
        int c = 0;
        for (int n = lo + 1; n <= hi; n++) if (strobe_hist[n] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_play(input int last);
        int c = 0;
        for (int n = 0; n <= last; n++) if (play_hist[n] === 1'b1) c++;
        return c;
    endfunction

    // Returns the first gap that differs from p inside note k (0 when regular).
    function automatic int bad_gap(input int k, input int p);
        int prev = 40 * k;
        for (int n = 40 * k + 1; n <= 40 * k + 40; n++) begin
            if (strobe_hist[n] === 1'b1) begin
                if (n - prev != p) return n - prev;
                prev = n;
            end
        end
        return 0;
    endfunction

    task automatic test_reset();
        logic quiet;
        nRst = 1'b0; good_coll = 1'b0; bad_coll = 1'b0;
`ifdef SFX_MUTE_EN
        mute = 1'b0;
`endif
        #2;
        assert_cnt++;
        if ({at_max, playing, note_idx, seq_bad} !== 5'b0) begin
            fail_cnt++;
            $display("[TB] FAIL reset_initial: got %b expected 00000", {at_max, playing, note_idx, seq_bad});
        end
        repeat (2) @(negedge tb_clk);
        nRst = 1'b1;
        pulse(1'b0, 1'b1);
        repeat (8) @(negedge tb_clk);
        assert_cnt++;
        if (at_max !== 1'b1) begin
            fail_cnt++;
            $display("[TB] FAIL reset_pre_strobe: at_max got %b expected 1", at_max);
        end
        #2 nRst = 1'b0;
        #2;
        assert_cnt++;
        if (at_max !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_at_max: got %b expected 0", at_max); end
        assert_cnt++;
        if (playing !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_playing: got %b expected 0", playing); end
        assert_cnt++;
        if (note_idx !== 2'd0) begin fail_cnt++; $display("[TB] FAIL reset_note_idx: got %0d expected 0", note_idx); end
        assert_cnt++;
        if (seq_bad !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_seq_bad: got %b expected 0", seq_bad); end
        @(negedge tb_clk);
        nRst = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge tb_clk);
            if ({at_max, playing, note_idx, seq_bad} !== 5'b0) quiet = 1'b0;
        end
        assert_cnt++;
        if (quiet !== 1'b1) begin fail_cnt++; $display("[TB] FAIL reset_idle_quiet: got %b expected 1", quiet); end
    endtask

    task automatic test_good_sequence();
        int exp_cnt [4] = '{5, 6, 10, 20};
        int got;
        pulse(1'b1, 1'b0);
        observe(175, -1);
        for (int k = 0; k < 4; k++) begin
            got = count_strobes(40 * k, 40 * k + 40);
            assert_cnt++;
            if (got != exp_cnt[k]) begin
                fail_cnt++;
                $display("[TB] FAIL good_note%0d_count: got %0d expected %0d", k, got, exp_cnt[k]);
            end
            got = bad_gap(k, 8 - 2 * k);
            assert_cnt++;
            if (got != 0) begin
                fail_cnt++;
                $display("[TB] FAIL good_note%0d_spacing: gap %0d expected %0d", k, got, 8 - 2 * k);
            end
            assert_cnt++;
            if (idx_hist[40 * k + 20] !== 2'(k)) begin
                fail_cnt++;
                $display("[TB] FAIL good_note%0d_idx: got %0d expected %0d", k, idx_hist[40 * k + 20], k);
            end
        end
        got = count_strobes(0, 174);
        assert_cnt++;
        if (got != 41) begin fail_cnt++; $display("[TB] FAIL good_total: got %0d expected 41", got); end
        got = count_play(174);
        assert_cnt++;
        if (got != 160 || play_hist[159] !== 1'b1 || play_hist[160] !== 1'b0) begin
            fail_cnt++;
            $display("[TB] FAIL good_playing_len: got %0d expected 160 ending at sample 159", got);
        end
        assert_cnt++;
        if (idx_hist[169] !== 2'd3 || idx_hist[170] !== 2'd0 || play_hist[169] !== 1'b0) begin
            fail_cnt++;
            $display("[TB] FAIL good_rest_len: idx at 169/170 got %0d/%0d expected 3/0", idx_hist[169], idx_hist[170]);
        end
        assert_cnt++;
        if (bad_hist[100] !== 1'b0) begin fail_cnt++; $display("[TB] FAIL good_seq_bad: got %b expected 0", bad_hist[100]); end
    endtask

    task automatic test_bad_sequence();
        int exp_cnt [4] = '{5, 4, 3, 2};
        int got;
        logic all_bad;
        pulse(1'b0, 1'b1);
        observe(175, -1);
        for (int k = 0; k < 4; k++) begin
            got = count_strobes(40 * k, 40 * k + 40);
            assert_cnt++;
            if (got != exp_cnt[k]) begin
                fail_cnt++;
                $display("[TB] FAIL bad_note%0d_count: got %0d expected %0d", k, got, exp_cnt[k]);
            end
            got = bad_gap(k, 8 + 2 * k);
            assert_cnt++;
            if (got != 0) begin
                fail_cnt++;
                $display("[TB] FAIL bad_note%0d_spacing: gap %0d expected %0d", k, got, 8 + 2 * k);
            end
        end
        got = count_strobes(0, 174);
        assert_cnt++;
        if (got != 14) begin fail_cnt++; $display("[TB] FAIL bad_total: got %0d expected 14", got); end
        got = count_play(174);
        assert_cnt++;
        if (got != 160) begin fail_cnt++; $display("[TB] FAIL bad_playing_len: got %0d expected 160", got); end
        all_bad = 1'b1;
        for (int n = 0; n < 175; n++) if (bad_hist[n] !== 1'b1) all_bad = 1'b0;
        assert_cnt++;
        if (all_bad !== 1'b1) begin fail_cnt++; $display("[TB] FAIL bad_seq_bad_held: got %b expected 1", all_bad); end
    endtask

    task automatic test_preempt();
        int got;
        pulse(1'b1, 1'b0);
        repeat (89) @(negedge tb_clk);
        assert_cnt++;
        if (note_idx !== 2'd2) begin fail_cnt++; $display("[TB] FAIL preempt_pre_idx: got %0d expected 2", note_idx); end
        bad_coll = 1'b1;
        @(negedge tb_clk);
        bad_coll = 1'b0;
        observe(175, -1);
        assert_cnt++;
        if (idx_hist[0] !== 2'd0 || bad_hist[0] !== 1'b1 || play_hist[0] !== 1'b1) begin
            fail_cnt++;
            $display("[TB] FAIL preempt_restart: idx/bad/play got %0d/%b/%b expected 0/1/1", idx_hist[0], bad_hist[0], play_hist[0]);
        end
        got = count_strobes(0, 7);
        assert_cnt++;
        if (got != 0 || strobe_hist[8] !== 1'b1) begin
            fail_cnt++;
            $display("[TB] FAIL preempt_first_strobe: early %0d at8 %b expected 0 and 1", got, strobe_hist[8]);
        end
        got = count_strobes(0, 174);
        assert_cnt++;
        if (got != 14) begin fail_cnt++; $display("[TB] FAIL preempt_total: got %0d expected 14", got); end
        got = count_play(174);
        assert_cnt++;
        if (got != 160) begin fail_cnt++; $display("[TB] FAIL preempt_playing_len: got %0d expected 160", got); end
    endtask

    task automatic test_ignore_good();
        int got;
        pulse(1'b0, 1'b1);
        observe(175, 50);
        got = count_strobes(0, 174);
        assert_cnt++;
        if (got != 14) begin fail_cnt++; $display("[TB] FAIL ignore_total: got %0d expected 14", got); end
        got = count_strobes(40, 80);
        assert_cnt++;
        if (got != 4) begin fail_cnt++; $display("[TB] FAIL ignore_note1_count: got %0d expected 4", got); end
        assert_cnt++;
        if (idx_hist[55] !== 2'd1 || bad_hist[55] !== 1'b1) begin
            fail_cnt++;
            $display("[TB] FAIL ignore_state: idx/bad got %0d/%b expected 1/1", idx_hist[55], bad_hist[55]);
        end
        got = count_play(174);
        assert_cnt++;
        if (got != 160) begin fail_cnt++; $display("[TB] FAIL ignore_playing_len: got %0d expected 160", got); end
    endtask

    task automatic test_simultaneous();
        int got;
        pulse(1'b1, 1'b1);
        observe(175, -1);
        assert_cnt++;
        if (bad_hist[0] !== 1'b1) begin fail_cnt++; $display("[TB] FAIL simul_seq_bad: got %b expected 1", bad_hist[0]); end
        got = count_strobes(40, 80);
        assert_cnt++;
        if (got != 4 || strobe_hist[50] !== 1'b1) begin
            fail_cnt++;
            $display("[TB] FAIL simul_note1: count %0d at50 %b expected 4 and 1", got, strobe_hist[50]);
        end
    endtask

    task automatic test_rest_event();
        int got;
        pulse(1'b0, 1'b1);
        observe(200, 164);
        assert_cnt++;
        if (idx_hist[164] !== 2'd3 || play_hist[164] !== 1'b0) begin
            fail_cnt++;
            $display("[TB] FAIL rest_state: idx/play got %0d/%b expected 3/0", idx_hist[164], play_hist[164]);
        end
        assert_cnt++;
        if (play_hist[165] !== 1'b1 || bad_hist[165] !== 1'b0 || idx_hist[165] !== 2'd0) begin
            fail_cnt++;
            $display("[TB] FAIL rest_restart: play/bad/idx got %b/%b/%0d expected 1/0/0", play_hist[165], bad_hist[165], idx_hist[165]);
        end
        got = count_strobes(160, 172);
        assert_cnt++;
        if (got != 0 || strobe_hist[173] !== 1'b1) begin
            fail_cnt++;
            $display("[TB] FAIL rest_first_strobe: early %0d at173 %b expected 0 and 1", got, strobe_hist[173]);
        end
        repeat (200) @(negedge tb_clk);
    endtask

`ifdef SFX_MUTE_EN
    task automatic test_mute();
        int got;
        mute = 1'b1;
        pulse(1'b1, 1'b0);
        for (int n = 0; n < 175; n++) begin
            if (n > 0) @(negedge tb_clk);
            strobe_hist[n] = at_max;
            play_hist[n]   = playing;
            if (n == 79) mute = 1'b0;
        end
        got = count_strobes(0, 80);
        assert_cnt++;
        if (got != 0) begin fail_cnt++; $display("[TB] FAIL mute_notes01: got %0d expected 0", got); end
        got = count_strobes(80, 120);
        assert_cnt++;
        if (got != 10) begin fail_cnt++; $display("[TB] FAIL mute_note2: got %0d expected 10", got); end
        got = count_strobes(120, 160);
        assert_cnt++;
        if (got != 20) begin fail_cnt++; $display("[TB] FAIL mute_note3: got %0d expected 20", got); end
        got = count_play(174);
        assert_cnt++;
        if (got != 160) begin fail_cnt++; $display("[TB] FAIL mute_playing_len: got %0d expected 160", got); end
    endtask
`endif

    initial begin
        test_reset();
        test_good_sequence();
        test_bad_sequence();
        test_preempt();
        test_ignore_good();
        test_simultaneous();
        test_rest_event();
`ifdef SFX_MUTE_EN
        test_mute();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
